calc_q_serializer: RTL and testbench

- Downstream stage of the calc core. Accepts one signed result Q = (a-b)(1+3c)-4d per valid/ready transfer, Q_DWIDTH bits wide (68 with default operand widths).
- Emits Q as a stream of OUT_DWIDTH-bit beats with a last flag, for narrow consumers such as a 32-bit AXI-Stream bridge or UART framer.
- Holds one result at a time. With no bubbles it sustains one result every BEATS cycles.

---
 rtl/calc_pkg.sv | 16 +
 rtl/calc_q_serializer.sv | 114 +++++++++++
 tb/tb_calc_q_serializer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared constants and types for the calc core and its downstream result serializer.
package calc_pkg;

    localparam int unsigned OP_DWIDTH = 32;
    // (a-b)(1+3c)-4d with 32-bit operands needs 68 bits signed.
    localparam int unsigned Q_DWIDTH  = 68;

    localparam int unsigned SER_OUT_DWIDTH = 32;
    localparam int unsigned SER_BEATS      = (Q_DWIDTH + SER_OUT_DWIDTH - 1) / SER_OUT_DWIDTH;

    typedef enum logic [0:0] {
        SER_IDLE,
        SER_SEND
    } ser_state_t;

endpackage

// File: rtl/calc_q_serializer.sv
// Splits one signed result Q into OUT_DWIDTH-bit beats with a last flag, LSB beat first.
// Define CALC_SER_MSB_FIRST_EN to emit the most significant beat first instead.
module calc_q_serializer
    import calc_pkg::*;
#(
    parameter int unsigned IN_DWIDTH  = Q_DWIDTH,
    parameter int unsigned OUT_DWIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [IN_DWIDTH-1:0]  in_data_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    output logic [OUT_DWIDTH-1:0] out_data_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic                  out_last_o,
    output logic [CNT_WIDTH-1:0]  res_cnt_o
);

    localparam int unsigned BEATS_RAW = (IN_DWIDTH + OUT_DWIDTH - 1) / OUT_DWIDTH;
    localparam int unsigned BEATS     = (BEATS_RAW < 1) ? 1 : BEATS_RAW;
    localparam int unsigned EXT_W     = BEATS * OUT_DWIDTH;
    localparam int unsigned LAST_BEAT = BEATS - 1;
    localparam int unsigned BW        = (BEATS > 1) ? $clog2(BEATS) : 1;

    ser_state_t            state_q, state_d;
    logic [EXT_W-1:0]      hold_q, hold_d;
    logic [BW-1:0]         beat_q, beat_d;
    logic [CNT_WIDTH-1:0]  res_cnt_q, res_cnt_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;
    logic [OUT_DWIDTH-1:0] out_data_q, out_data_d;

    logic [EXT_W-1:0]      q_ext;
    logic [BW-1:0]         beat_nxt;
    logic                  capture;

    function automatic logic [OUT_DWIDTH-1:0] beat_sel(input logic [EXT_W-1:0] h,
                                                       input int unsigned      k);
`ifdef CALC_SER_MSB_FIRST_EN
        return h[(LAST_BEAT - k) * OUT_DWIDTH +: OUT_DWIDTH];
`else
        return h[k * OUT_DWIDTH +: OUT_DWIDTH];
`endif
    endfunction

    assign q_ext    = EXT_W'($signed(in_data_i));
    assign beat_nxt = beat_q + BW'(1);

    // Last-beat handshake frees the holding register in the same cycle: no bubble.
    assign in_ready_o = (state_q == SER_IDLE) |
                        ((state_q == SER_SEND) & out_last_q & out_ready_i);
    assign capture    = in_valid_i & in_ready_o;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        beat_d      = beat_q;
        res_cnt_d   = res_cnt_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;

        if ((state_q == SER_SEND) && out_ready_i) begin
            if (out_last_q) begin
                res_cnt_d   = res_cnt_q + CNT_WIDTH'(1);
                state_d     = SER_IDLE;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end else begin
                beat_d     = beat_nxt;
                out_data_d = beat_sel(hold_q, 32'(beat_nxt));
                out_last_d = (32'(beat_nxt) == LAST_BEAT);
            end
        end

        if (capture) begin
            hold_d      = q_ext;
            beat_d      = '0;
            state_d     = SER_SEND;
            out_valid_d = 1'b1;
            out_last_d  = (LAST_BEAT == 0);
            out_data_d  = beat_sel(q_ext, 0);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= SER_IDLE;
            hold_q      <= '0;
            beat_q      <= '0;
            res_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            beat_q      <= beat_d;
            res_cnt_q   <= res_cnt_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_data_o  = out_data_q;
    assign out_valid_o = out_valid_q;
    assign out_last_o  = out_last_q;
    assign res_cnt_o   = res_cnt_q;

endmodule

// File: tb/tb_calc_q_serializer.sv
// Directed bench for calc_q_serializer at default widths (68-bit Q, 32-bit beats, 3 beats).
module tb_calc_q_serializer;

    logic        clk;
    logic        rst_ni;
    logic [67:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic [15:0] res_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    calc_q_serializer dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .in_data_i  (in_data),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .out_data_o (out_data),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_last_o (out_last),
        .res_cnt_o  (res_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected beats are given LSB-first; reorder for the MSB-first build.
    function automatic logic [31:0] ex(input logic [31:0] e0, input logic [31:0] e1,
                                       input logic [31:0] e2, input int k);
        logic [31:0] e [3];
        e[0] = e0;
        e[1] = e1;
        e[2] = e2;
`ifdef CALC_SER_MSB_FIRST_EN
        return e[2-k];
`else
        return e[k];
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_q(input string name, input logic [67:0] q, input logic [31:0] e0,
                          input logic [31:0] e1, input logic [31:0] e2,
                          input logic [15:0] cnt_exp);
        in_data   = q;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk({name, " idle in_ready"}, 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("%s beat%0d valid", name, k), 64'(out_valid), 64'd1);
            chk($sformatf("%s beat%0d data", name, k), 64'(out_data), 64'(ex(e0, e1, e2, k)));
            chk($sformatf("%s beat%0d last", name, k), 64'(out_last), 64'(k == 2));
            chk($sformatf("%s beat%0d in_ready", name, k), 64'(in_ready), 64'(k == 2));
            tick();
        end
        chk({name, " done valid"}, 64'(out_valid), 64'd0);
        chk({name, " res_cnt"}, 64'(res_cnt), 64'(cnt_exp));
    endtask

    initial begin
        int k;
        int beats;

        rst_ni    = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2;
        chk("reset valid", 64'(out_valid), 64'd0);
        chk("reset last", 64'(out_last), 64'd0);
        chk("reset data", 64'(out_data), 64'd0);
        chk("reset res_cnt", 64'(res_cnt), 64'd0);
        chk("reset in_ready", 64'(in_ready), 64'd1);
        #10;
        rst_ni = 1'b1;
        tick();

        send_q("neg1", {68{1'b1}}, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 16'd1);
        send_q("lsbfirst", 68'h0_00000002_00000001, 32'h00000001, 32'h00000002, 32'h0, 16'd2);
        send_q("sext", 68'h8_00000000_00000000, 32'h0, 32'h0, 32'hFFFFFFF8, 16'd3);

        // Stalled transfer; in_valid held with junk data must not be captured mid-result.
        in_data   = 68'h3_BBBBBBBB_AAAAAAAA;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        in_data = 68'h5_55555555_55555555;
        k       = 0;
        beats   = 0;
        for (int i = 0; i < 20 && k < 3; i++) begin
            out_ready = (i % 3 == 0);
            in_valid  = (k < 2);
            #1;
            chk($sformatf("stall c%0d valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("stall c%0d data", i), 64'(out_data),
                64'(ex(32'hAAAAAAAA, 32'hBBBBBBBB, 32'h00000003, k)));
            chk($sformatf("stall c%0d last", i), 64'(out_last), 64'(k == 2));
            chk($sformatf("stall c%0d in_ready", i), 64'(in_ready), 64'(k == 2 && out_ready));
            if (out_ready) begin
                k++;
                beats++;
            end
            tick();
        end
        chk("stall beats", 64'(beats), 64'd3);
        chk("stall done valid", 64'(out_valid), 64'd0);
        chk("stall res_cnt", 64'(res_cnt), 64'd4);

        // Back-to-back: second Q captured on the first Q's last beat.
        in_data   = 68'h1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_data = 68'hF_FFFFFFFF_FFFFFFFE;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) in_valid = 1'b0;
            #1;
            chk($sformatf("b2b beat%0d valid", i), 64'(out_valid), 64'd1);
            if (i < 3) begin
                chk($sformatf("b2b beat%0d data", i), 64'(out_data),
                    64'(ex(32'h1, 32'h0, 32'h0, i)));
            end else begin
                chk($sformatf("b2b beat%0d data", i), 64'(out_data),
                    64'(ex(32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, i - 3)));
            end
            chk($sformatf("b2b beat%0d last", i), 64'(out_last), 64'(i == 2 || i == 5));
            chk($sformatf("b2b beat%0d in_ready", i), 64'(in_ready), 64'(i == 2 || i == 5));
            if (i == 3) chk("b2b mid res_cnt", 64'(res_cnt), 64'd5);
            tick();
        end
        chk("b2b done valid", 64'(out_valid), 64'd0);
        chk("b2b res_cnt", 64'(res_cnt), 64'd6);

        // Reset mid-result drops it.
        in_data   = 68'd5;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        #1;
        chk("rst beat0 data", 64'(out_data), 64'(ex(32'h5, 32'h0, 32'h0, 0)));
        tick();
        chk("rst beat1 valid", 64'(out_valid), 64'd1);
        rst_ni = 1'b0;
        #1;
        chk("rst async valid", 64'(out_valid), 64'd0);
        chk("rst async res_cnt", 64'(res_cnt), 64'd0);
        chk("rst async data", 64'(out_data), 64'd0);
        #5;
        rst_ni = 1'b1;
        tick();
        chk("rst release in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst leftover c%0d", i), 64'(out_valid), 64'd0);
            tick();
        end
        send_q("q5", 68'd5, 32'h5, 32'h0, 32'h0, 16'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
